// File: rtl/ram_loader.sv
// Boot-time loader: accepts a framed byte stream (length, payload, checksum),
// writes the payload into an async-read RAM from address 0, then verifies it by readback.
module ram_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data_in,
    input  logic                  cpu_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH:0] MAX_LEN = (DATA_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_VERIFY,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         count, count_d;
    logic [CW-1:0]         len, len_d;
    logic [DATA_WIDTH-1:0] sum, sum_d;
    logic [1:0]            err, err_d;

    logic                  xfer;
    logic                  last;
    logic [DATA_WIDTH-1:0] verify_sum;

    assign xfer       = in_valid && in_ready;
    assign last       = (count == len - CW'(1));
    assign verify_sum = sum + ram_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            len   <= '0;
            sum   <= '0;
            err   <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            len   <= len_d;
            sum   <= sum_d;
            err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        len_d   = len;
        sum_d   = sum;
        err_d   = err;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    err_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (in_data == '0 || {1'b0, in_data} > MAX_LEN) begin
                        state_d = S_ERR;
                        err_d   = 2'd1;
                    end else begin
                        len_d   = CW'(in_data);
                        count_d = '0;
                        sum_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    sum_d   = sum + in_data;
                    count_d = count + CW'(1);
                    if (last) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                // The write-pass sum is dropped; the checksum byte seeds the readback sum.
                if (xfer) begin
                    sum_d   = in_data;
                    count_d = '0;
                    state_d = S_VERIFY;
                end
            end
            S_VERIFY: begin
                sum_d   = verify_sum;
                count_d = count + CW'(1);
                if (last) begin
                    if (verify_sum == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'd2;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_addr    = cpu_addr;
        ram_data_in = cpu_data_in;
        ram_we      = cpu_we;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (state)
            S_LEN, S_CSUM: begin
                ram_addr    = count[ADDR_WIDTH-1:0];
                ram_data_in = in_data;
                ram_we      = 1'b0;
                in_ready    = 1'b1;
                busy        = 1'b1;
            end
            S_DATA: begin
                ram_addr    = count[ADDR_WIDTH-1:0];
                ram_data_in = in_data;
                ram_we      = in_valid;
                in_ready    = 1'b1;
                busy        = 1'b1;
            end
            S_VERIFY: begin
                ram_addr    = count[ADDR_WIDTH-1:0];
                ram_data_in = in_data;
                ram_we      = 1'b0;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);
    assign err_code = err;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a behavioural 32x8 RAM on the loader's RAM port, with
// outcomes and RAM contents predicted from the framing and checksum rules.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_data_in = '0;
    logic       cpu_we = 1'b0;
    logic [4:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       ram_we;
    logic [7:0] ram_data_out;
    logic       busy, done, error;
    logic [1:0] err_code;

    logic [7:0] mem [0:31];
    logic [7:0] exp_mem [0:31];
    logic [7:0] pay [0:31];
    int         wr_count = 0;
    int         cycle = 0;
    int         checks = 0;
    int         passed = 0;
    int         fails = 0;

    ram_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_we(cpu_we),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
        .ram_data_out(ram_data_out),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data_in;
            wr_count      <= wr_count + 1;
        end
        cycle <= cycle + 1;
    end
    assign ram_data_out = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        int k;
        in_valid = 1'b0;
        repeat (idle) tick();
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check("ready_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int gap_for(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return ($urandom_range(0, 2) == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic compare_ram(input string tag);
        for (int i = 0; i < 32; i++) begin
            cpu_addr = 5'(i);
            #1;
            check($sformatf("%s_ram%0d", tag, i), ram_data_out, exp_mem[i]);
        end
    endtask

    task automatic do_load(input logic [7:0] lenb, input int n, input logic [7:0] csum,
                           input int gap, input bit noise, input bit midstart, input string tag);
        int s, e, w0, k, exp_err;
        bit ok_len;
        logic [7:0] total;
        ok_len = (lenb != 0) && (lenb <= 32);
        w0 = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cycle;
        if (noise) begin
            cpu_we = 1'b1;
            cpu_addr = 5'd4;
            cpu_data_in = 8'hEE;
        end
        send(lenb, 0);
        if (ok_len) begin
            for (int i = 0; i < n; i++) begin
                send(pay[i], gap_for(gap));
                if (midstart && i == 0) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    check({tag, "_midstart_busy"}, busy, 1);
                    check({tag, "_midstart_ready"}, in_ready, 1);
                    check({tag, "_midstart_addr"}, ram_addr, 1);
                end
            end
            send(csum, gap_for(gap));
        end
        k = 0;
        while (!(done || error) && k < 200) begin
            tick();
            k++;
        end
        cpu_we = 1'b0;
        if (k >= 200) check({tag, "_end_timeout"}, done | error, 1);
        e = cycle;

        if (!ok_len) begin
            exp_err = 1;
        end else begin
            total = csum;
            for (int i = 0; i < n; i++) begin
                total += pay[i];
                exp_mem[i] = pay[i];
            end
            exp_err = (total == 0) ? 0 : 2;
        end
        check({tag, "_done"}, done, exp_err == 0);
        check({tag, "_error"}, error, exp_err != 0);
        check({tag, "_err_code"}, err_code, exp_err);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_writes"}, wr_count - w0, ok_len ? n : 0);
        if (gap == 0 && !midstart)
            check({tag, "_latency"}, e - s + 1, ok_len ? 2 * n + 3 : 2);
    endtask

    initial begin
        int n;
        logic [7:0] t;
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_ready", in_ready, 0);
        check("rst_err_code", err_code, 0);
        cpu_addr = 5'd3;
        cpu_data_in = 8'h5A;
        #1;
        check("idle_pass_addr", ram_addr, 3);
        check("idle_pass_data", ram_data_in, 8'h5A);
        check("idle_pass_we", ram_we, 0);

        cpu_addr = 5'd4; cpu_data_in = 8'h44; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        exp_mem[4] = 8'h44;

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        do_load(8'd3, 3, 8'h9A, 0, 0, 0, "basic");
        compare_ram("basic");

        do_load(8'h00, 0, 8'h00, 0, 0, 0, "len0");
        do_load(8'h21, 0, 8'h00, 0, 0, 0, "len33");

        pay[0] = 8'h55; pay[1] = 8'hAA;
        do_load(8'd2, 2, 8'h00, 0, 0, 0, "badsum");
        compare_ram("badsum");

        for (int i = 0; i < 32; i++) pay[i] = 8'hFF;
        do_load(8'd32, 32, 8'h20, 1, 0, 0, "full");
        compare_ram("full");

        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'd5, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        exp_mem[0] = 8'h01;
        exp_mem[1] = 8'h02;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_err_code", err_code, 0);
        cpu_addr = 5'd5; cpu_data_in = 8'h7E; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        exp_mem[5] = 8'h7E;
        check("cpu_write_rb", ram_data_out, 8'h7E);

        t = '0;
        for (int i = 0; i < 3; i++) begin
            pay[i] = 8'($urandom_range(0, 255));
            t += pay[i];
        end
        do_load(8'd3, 3, 8'(0 - t), 0, 1, 1, "noise");
        compare_ram("noise");

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 32);
            t = '0;
            for (int i = 0; i < n; i++) begin
                pay[i] = 8'($urandom_range(0, 255));
                t += pay[i];
            end
            if ($urandom_range(0, 5) == 0)
                do_load(8'($urandom_range(33, 255)), 0, 8'h00, 2, 0, 0, $sformatf("rnd%0d", r));
            else if ($urandom_range(0, 1) == 0)
                do_load(8'(n), n, 8'(0 - t), 2, 0, 0, $sformatf("rnd%0d", r));
            else
                do_load(8'(n), n, 8'(0 - t + $urandom_range(1, 255)), $urandom_range(0, 2), 0, 0,
                        $sformatf("rnd%0d", r));
        end
        compare_ram("final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time program loader that sits directly upstream of the 32x8 async-read RAM and drives its addr, data_in and we.
- Accepts a framed byte stream over a valid/ready handshake: a length byte, N payload bytes, then a checksum byte.
- Writes the payload into RAM from address 0, then reads it back over the async read port to verify the checksum.
- While idle it passes the CPU's RAM port through unchanged.

Parameters:
- ADDR_WIDTH, 5, RAM address width; DEPTH = 2**ADDR_WIDTH = 32.
- DATA_WIDTH, 8, byte width of the stream and the RAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- cpu_addr  in  ADDR_WIDTH  CPU RAM address.
- cpu_data_in  in  DATA_WIDTH  CPU write data.
- cpu_we  in  1  CPU write enable.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_we  out  1  to RAM we.
- ram_data_out  in  DATA_WIDTH  from RAM data_out (async read).
- busy  out  1  high in LEN, DATA, CSUM, VERIFY.
- done  out  1  load verified OK.
- error  out  1  load failed.
- err_code  out  2  0 none, 1 bad length, 2 checksum mismatch.

Behaviour:
- States: IDLE, LEN, DATA, CSUM, VERIFY, DONE, ERR. Outputs are decoded from the state register (Moore); RAM drive and in_ready are combinational from state.
- A byte transfers when in_valid && in_ready at a rising edge.
- Reset: state=IDLE, count=0, len=0, sum=0, err_code=0. Consequently busy=0, done=0, error=0, in_ready=0. Reset in any state takes effect at the next edge. RAM contents are untouched because the RAM has no reset.
- IDLE/DONE/ERR:
  - ram_addr=cpu_addr, ram_data_in=cpu_data_in, ram_we=cpu_we; in_ready=0.
  - start -> LEN, clearing err_code.
- LEN:
  - in_ready=1, ram_we=0.
  - On transfer: if in_data==0 or in_data>DEPTH -> ERR with err_code=1.
  - Otherwise len<=in_data, count<=0, sum<=0 -> DATA.
- DATA:
  - in_ready=1; ram_addr=count, ram_data_in=in_data, ram_we=in_valid, so the write coincides with the transfer edge.
  - On transfer: sum<=sum+in_data (mod 256), count<=count+1.
  - When the transfer has count==len-1 -> CSUM.
  - Cycles without in_valid hold everything and write nothing.
  - count is ADDR_WIDTH+1 bits wide so that len=32 does not wrap.
- CSUM:
  - in_ready=1, ram_we=0.
  - On transfer: sum<=in_data (seeds the verify accumulator), count<=0 -> VERIFY.
  - The sum of the write pass is discarded; verification is based only on readback.
- VERIFY:
  - in_ready=0, ram_we=0, ram_addr=count.
  - Each cycle: sum<=sum+ram_data_out, count<=count+1.
  - Runs exactly len cycles. On the cycle with count==len-1, the final sum (including that byte) is tested: if 0 -> DONE, else ERR with err_code=2.
- DONE: done=1. ERR: error=1 with err_code held. Both persist until start or rst.
- start is ignored in LEN, DATA, CSUM and VERIFY.
- cpu_we, cpu_addr and cpu_data_in are ignored (not forwarded) while busy.
- Latency with in_valid held high: start edge -> LEN; then 1+N+1 transfer cycles; then N verify cycles; done/error are visible in the cycle after the final verify edge. Total is 2N+3 cycles from the start edge.
- Checksum rule: (sum of payload bytes + checksum byte) mod 256 == 0.

Test Plan:
- start; stream 0x03,0x11,0x22,0x33,0x9A with continuous valid -> done=1 exactly 9 cycles after start, error=0. Then cpu_addr=0,1,2 reads 0x11,0x22,0x33 via ram_data_out.
- start; length byte 0x00 -> error=1, err_code=1, no RAM writes. Repeat with 0x21 -> same result.
- start; 0x02,0x55,0xAA,0x00 (correct checksum 0x01) -> error=1, err_code=2; RAM[0]=0x55 and RAM[1]=0xAA are still written.
- N=32 payload of 0xFF, checksum 0x20, with in_valid deasserted on alternate cycles -> done=1; addresses 0..31 all read 0xFF; no write occurs on idle cycles.
- During DATA after 2 bytes, assert rst for 1 cycle -> busy=0, done=0, error=0, in_ready=0. A cpu_we=1 write of 0x7E to address 5 then reads back 0x7E.
- While busy, drive cpu_we=1, cpu_addr=4, cpu_data_in=0xEE -> RAM[4] unchanged after DONE. A start pulse mid-DATA has no effect on state or count.
